// File: rtl/decode_stage_pkg.sv
// Shared types for the RV32I decode stage: pipeline bundles, ALU/memory enums,
// opcode constants and the reset PC.
package decode_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RIDX = 5;
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_e;

  typedef enum logic [1:0] {MEM_BYTE, MEM_HALF, MEM_WORD, MEM_RSVD} mem_size_e;

  typedef struct packed {
    logic            enable;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_info_t;

  typedef struct packed {
    logic stall;
    logic flush;
  } pipe_control_t;

  typedef struct packed {
    logic stall_req;
  } pipe_request_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [RIDX-1:0] rd;
    logic [RIDX-1:0] rs1;
    logic [RIDX-1:0] rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    alu_op_e         alu_op;
    logic            src_b_imm;
    logic            mem_read;
    logic            mem_write;
    mem_size_e       mem_size;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic            reg_write;
    logic            is_system;
    logic            illegal;
  } decode_info_t;

  // Register-register / register-immediate ALU selection; alt picks SUB/SRA.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Integer register file: two combinational read ports with write bypass, one write port.
module decode_stage_regfile
  import decode_stage_pkg::*;
#(
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RIDX-1:0] raddr_a,
  input  logic [RIDX-1:0] raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b,
  input  logic            we,
  input  logic [RIDX-1:0] waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) mem[i] <= '0;
    end else if (we && waddr != '0 && 32'(waddr) < NREGS) begin
      mem[waddr] <= wdata;
    end
  end

  function automatic logic [XLEN-1:0] rd_port(input logic [RIDX-1:0] a);
    if (a == '0 || 32'(a) >= NREGS) return '0;
    if (we && waddr == a)           return wdata;
    return mem[a];
  endfunction

  assign rdata_a = rd_port(raddr_a);
  assign rdata_b = rd_port(raddr_b);

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: full decode, register read, load-use hazard detection, ID/EX register.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC_P = RESET_PC,
  parameter int unsigned     NREGS      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  fetch_info_t     info,
  input  pipe_control_t   id_ex_pipe,
  output pipe_request_t   req,
  input  logic            ex_is_load,
  input  logic [RIDX-1:0] ex_rd,
  input  logic            wb_we,
  input  logic [RIDX-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output decode_info_t    out,
  output logic            error
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [RIDX-1:0] rs1, rs2;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            uses_rs1, uses_rs2, ill;
  logic            stall_req;
  decode_info_t    dec, bubble;

  assign opcode = info.inst[6:0];
  assign funct3 = info.inst[14:12];
  assign funct7 = info.inst[31:25];
  assign rs1    = info.inst[19:15];
  assign rs2    = info.inst[24:20];

  assign imm_i = {{20{info.inst[31]}}, info.inst[31:20]};
  assign imm_s = {{20{info.inst[31]}}, info.inst[31:25], info.inst[11:7]};
  assign imm_b = {{19{info.inst[31]}}, info.inst[31], info.inst[7], info.inst[30:25],
                  info.inst[11:8], 1'b0};
  assign imm_u = {info.inst[31:12], 12'h000};
  assign imm_j = {{11{info.inst[31]}}, info.inst[31], info.inst[19:12], info.inst[20],
                  info.inst[30:21], 1'b0};

  decode_stage_regfile #(.NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .raddr_a (rs1),
    .raddr_b (rs2),
    .rdata_a (rs1_val),
    .rdata_b (rs2_val),
    .we      (wb_we),
    .waddr   (wb_rd),
    .wdata   (wb_data)
  );

  // Instruction decode into the ID/EX payload.
  always_comb begin
    dec      = '0;
    ill      = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    dec.pc      = info.pc;
    dec.rd      = info.inst[11:7];
    dec.rs1     = rs1;
    dec.rs2     = rs2;
    dec.funct3  = funct3;
    dec.rs1_val = rs1_val;
    dec.rs2_val = rs2_val;
    dec.alu_op  = ALU_ADD;
    case (opcode)
      OP_LUI:    begin dec.imm = imm_u; dec.alu_op = ALU_PASS_B; dec.src_b_imm = 1'b1; dec.reg_write = 1'b1; end
      OP_AUIPC:  begin dec.imm = imm_u; dec.src_b_imm = 1'b1; dec.reg_write = 1'b1; end
      OP_JAL:    begin dec.imm = imm_j; dec.jal = 1'b1; dec.reg_write = 1'b1; end
      OP_JALR: begin
        dec.imm = imm_i; dec.jalr = 1'b1; dec.reg_write = 1'b1; uses_rs1 = 1'b1;
        ill = (funct3 != 3'd0);
      end
      OP_BRANCH: begin
        dec.imm = imm_b; dec.branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        ill = (funct3[2:1] == 2'b01);
      end
      OP_LOAD: begin
        dec.imm = imm_i; dec.mem_read = 1'b1; dec.src_b_imm = 1'b1; dec.reg_write = 1'b1;
        dec.mem_size = mem_size_e'(funct3[1:0]); uses_rs1 = 1'b1;
        ill = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OP_STORE: begin
        dec.imm = imm_s; dec.mem_write = 1'b1; dec.src_b_imm = 1'b1;
        dec.mem_size = mem_size_e'(funct3[1:0]); uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        ill = (funct3 > 3'd2);
      end
      OP_IMM: begin
        dec.imm = imm_i; dec.src_b_imm = 1'b1; dec.reg_write = 1'b1; uses_rs1 = 1'b1;
        dec.alu_op = alu_from_funct3(funct3, (funct3 == 3'd5) && funct7[5]);
        if (funct3 == 3'd1)      ill = (funct7 != 7'h00);
        else if (funct3 == 3'd5) ill = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OP_OP: begin
        dec.reg_write = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        dec.alu_op = alu_from_funct3(funct3, funct7[5]);
        ill = !((funct7 == 7'h00) || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)));
      end
      OP_MISC:   ;
      OP_SYSTEM: begin dec.imm = imm_i; dec.is_system = 1'b1; end
      default:   ill = 1'b1;
    endcase
    if (dec.rd == '0) dec.reg_write = 1'b0;
    dec.valid   = info.enable;
    dec.illegal = info.enable && ill;
  end

  assign stall_req = !rst && info.enable && ex_is_load && (ex_rd != '0) &&
                     ((uses_rs1 && rs1 == ex_rd) || (uses_rs2 && rs2 == ex_rd));
  assign req.stall_req = stall_req;

  always_comb begin
    bubble    = '0;
    bubble.pc = info.pc;
  end

  // ID/EX register: reset > flush > hold > hazard bubble > load.
  always_ff @(posedge clk) begin
    if (rst) begin
      out    <= '0;
      out.pc <= RESET_PC_P;
      error  <= 1'b0;
    end else if (id_ex_pipe.flush) begin
      out    <= '0;
      out.pc <= RESET_PC_P;
      error  <= 1'b0;
    end else if (id_ex_pipe.stall) begin
      out   <= out;
      error <= error;
    end else if (stall_req) begin
      out   <= bubble;
      error <= 1'b0;
    end else begin
      out   <= dec;
      error <= dec.valid && dec.illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  fetch_info_t     info;
  pipe_control_t   id_ex_pipe;
  pipe_request_t   req;
  logic            ex_is_load;
  logic [4:0]      ex_rd;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [31:0]     wb_data;
  decode_info_t    dout;
  logic            error;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage #(.NREGS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .info       (info),
    .id_ex_pipe (id_ex_pipe),
    .req        (req),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .out        (dout),
    .error      (error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0;
    info = '0;
    id_ex_pipe = '0;
    ex_is_load = 1'b0;
    ex_rd = '0;
    wb_we = 1'b0;
    wb_rd = '0;
    wb_data = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    info = '{enable: 1'b1, pc: 32'h100, inst: 32'h001102B3};
    ex_is_load = 1'b1; ex_rd = 5'd2;
    tick();
    #1;
    total++; if (req.stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall_req got=%b exp=0", req.stall_req); end
    total++; if (dout.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", dout.valid); end
    total++; if (dout.pc !== 32'h80000000) begin bad++; $display("FAIL reset_pc got=%h exp=80000000", dout.pc); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", error); end
    total++; if (dout.reg_write !== 1'b0 || dout.imm !== 32'h0) begin bad++; $display("FAIL reset_fields got rw=%b imm=%h exp 0", dout.reg_write, dout.imm); end
    idle();
  endtask

  task automatic test_addi();
    info = '{enable: 1'b1, pc: 32'h80000000, inst: 32'h00500093};
    tick();
    total++; if (dout.valid !== 1'b1) begin bad++; $display("FAIL addi_valid got=%b exp=1", dout.valid); end
    total++; if (dout.rd !== 5'd1) begin bad++; $display("FAIL addi_rd got=%0d exp=1", dout.rd); end
    total++; if (dout.imm !== 32'd5) begin bad++; $display("FAIL addi_imm got=%h exp=5", dout.imm); end
    total++; if (dout.reg_write !== 1'b1 || dout.src_b_imm !== 1'b1) begin bad++; $display("FAIL addi_ctrl got rw=%b sbi=%b exp 1 1", dout.reg_write, dout.src_b_imm); end
    total++; if (dout.alu_op !== ALU_ADD) begin bad++; $display("FAIL addi_alu got=%0d exp=%0d", dout.alu_op, ALU_ADD); end
    total++; if (error !== 1'b0) begin bad++; $display("FAIL addi_error got=%b exp=0", error); end
    idle();
  endtask

  task automatic test_bypass();
    info = '{enable: 1'b1, pc: 32'h80000004, inst: 32'h00018233};
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    tick();
    total++; if (dout.rs1_val !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_rs1 got=%h exp=deadbeef", dout.rs1_val); end
    total++; if (dout.rd !== 5'd4 || dout.rs2_val !== 32'h0) begin bad++; $display("FAIL bypass_rd_rs2 got rd=%0d rs2=%h exp 4 0", dout.rd, dout.rs2_val); end
    wb_we = 1'b0;
    tick();
    total++; if (dout.rs1_val !== 32'hDEADBEEF) begin bad++; $display("FAIL stored_rs1 got=%h exp=deadbeef", dout.rs1_val); end
    info.inst = 32'h00000233;
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h12345678;
    tick();
    wb_we = 1'b0;
    tick();
    total++; if (dout.rs1_val !== 32'h0 || dout.rs2_val !== 32'h0) begin bad++; $display("FAIL x0_read got rs1=%h rs2=%h exp 0 0", dout.rs1_val, dout.rs2_val); end
    idle();
  endtask

  task automatic test_hazard();
    info = '{enable: 1'b1, pc: 32'h80000010, inst: 32'h001102B3};
    ex_is_load = 1'b1; ex_rd = 5'd2;
    #1;
    total++; if (req.stall_req !== 1'b1) begin bad++; $display("FAIL hazard_req got=%b exp=1", req.stall_req); end
    tick();
    total++; if (dout.valid !== 1'b0) begin bad++; $display("FAIL hazard_bubble got=%b exp=0", dout.valid); end
    ex_is_load = 1'b0;
    #1;
    total++; if (req.stall_req !== 1'b0) begin bad++; $display("FAIL hazard_noload got=%b exp=0", req.stall_req); end
    tick();
    total++; if (dout.valid !== 1'b1 || dout.rd !== 5'd5) begin bad++; $display("FAIL hazard_release got v=%b rd=%0d exp 1 5", dout.valid, dout.rd); end
    ex_is_load = 1'b1; ex_rd = 5'd1;
    #1;
    total++; if (req.stall_req !== 1'b1) begin bad++; $display("FAIL hazard_rs2 got=%b exp=1", req.stall_req); end
    ex_rd = 5'd0;
    info.inst = 32'h000002B3;
    #1;
    total++; if (req.stall_req !== 1'b0) begin bad++; $display("FAIL hazard_x0 got=%b exp=0", req.stall_req); end
    info.enable = 1'b0; ex_rd = 5'd2; info.inst = 32'h001102B3;
    #1;
    total++; if (req.stall_req !== 1'b0) begin bad++; $display("FAIL hazard_disabled got=%b exp=0", req.stall_req); end
    idle();
  endtask

  task automatic test_illegal_hold_flush();
    info = '{enable: 1'b1, pc: 32'h80000020, inst: 32'hFFFFFFFF};
    tick();
    total++; if (dout.valid !== 1'b1 || error !== 1'b1) begin bad++; $display("FAIL illegal_error got v=%b err=%b exp 1 1", dout.valid, error); end
    info = '0;
    id_ex_pipe.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (error !== 1'b1 || dout.pc !== 32'h80000020) begin bad++; $display("FAIL stall_hold%0d got err=%b pc=%h exp 1 80000020", i, error, dout.pc); end
    end
    id_ex_pipe = '{stall: 1'b0, flush: 1'b1};
    tick();
    total++; if (error !== 1'b0 || dout.pc !== 32'h80000000 || dout.valid !== 1'b0) begin bad++; $display("FAIL flush got err=%b pc=%h v=%b exp 0 80000000 0", error, dout.pc, dout.valid); end
    id_ex_pipe = '0;
    info = '{enable: 1'b1, pc: 32'h80000030, inst: 32'h40001033};
    tick();
    total++; if (error !== 1'b1) begin bad++; $display("FAIL op_funct7 got=%b exp=1", error); end
    info.inst = 32'h00002063;
    tick();
    total++; if (error !== 1'b1) begin bad++; $display("FAIL branch_f3 got=%b exp=1", error); end
    info.inst = 32'h0000100F;
    tick();
    total++; if (error !== 1'b0 || dout.reg_write !== 1'b0) begin bad++; $display("FAIL fence got err=%b rw=%b exp 0 0", error, dout.reg_write); end
    info.enable = 1'b0; info.inst = 32'hFFFFFFFF;
    tick();
    total++; if (error !== 1'b0 || dout.valid !== 1'b0) begin bad++; $display("FAIL disabled_illegal got err=%b v=%b exp 0 0", error, dout.valid); end
    idle();
  endtask

  task automatic test_imm();
    info = '{enable: 1'b1, pc: 32'h80000040, inst: 32'hFE000EE3};
    tick();
    total++; if (dout.imm !== 32'hFFFFFFFC || dout.branch !== 1'b1) begin bad++; $display("FAIL beq_imm got imm=%h br=%b exp fffffffc 1", dout.imm, dout.branch); end
    info.inst = 32'h001000EF;
    tick();
    total++; if (dout.imm !== 32'h00000800 || dout.jal !== 1'b1 || dout.rd !== 5'd1) begin bad++; $display("FAIL jal_imm got imm=%h jal=%b rd=%0d exp 00000800 1 1", dout.imm, dout.jal, dout.rd); end
    info.inst = 32'hABCDE0B7;
    tick();
    total++; if (dout.imm !== 32'hABCDE000 || dout.alu_op !== ALU_PASS_B) begin bad++; $display("FAIL lui_imm got imm=%h alu=%0d exp abcde000 %0d", dout.imm, dout.alu_op, ALU_PASS_B); end
    info.inst = 32'hFE112E23;
    tick();
    total++; if (dout.imm !== 32'hFFFFFFFC || dout.mem_write !== 1'b1 || dout.mem_size !== MEM_WORD) begin bad++; $display("FAIL sw_imm got imm=%h mw=%b sz=%0d exp fffffffc 1 2", dout.imm, dout.mem_write, dout.mem_size); end
    idle();
  endtask

  task automatic test_flush_stall();
    info = '{enable: 1'b1, pc: 32'h80000050, inst: 32'h00500093};
    id_ex_pipe = '{stall: 1'b1, flush: 1'b1};
    tick();
    total++; if (dout.valid !== 1'b0 || dout.pc !== 32'h80000000) begin bad++; $display("FAIL flush_wins got v=%b pc=%h exp 0 80000000", dout.valid, dout.pc); end
    idle();
  endtask

  task automatic test_reset_mid();
    info = '{enable: 1'b1, pc: 32'h80000060, inst: 32'h00500093};
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h12345678;
    tick();
    wb_we = 1'b0;
    info.inst = 32'h00018233;
    tick();
    total++; if (dout.rs1_val !== 32'h12345678) begin bad++; $display("FAIL premid_rs1 got=%h exp=12345678", dout.rs1_val); end
    rst = 1'b1;
    tick();
    total++; if (dout.valid !== 1'b0 || dout.pc !== 32'h80000000 || error !== 1'b0 || dout.rs1_val !== 32'h0) begin bad++; $display("FAIL midreset got v=%b pc=%h err=%b rs1=%h exp 0 80000000 0 0", dout.valid, dout.pc, error, dout.rs1_val); end
    rst = 1'b0;
    tick();
    total++; if (dout.valid !== 1'b1 || dout.rs1_val !== 32'h0) begin bad++; $display("FAIL rf_cleared got v=%b rs1=%h exp 1 0", dout.valid, dout.rs1_val); end
    idle();
  endtask

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_addi();
    test_bypass();
    test_hazard();
    test_illegal_hold_flush();
    test_imm();
    test_flush_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I instruction-decode stage, directly downstream of fetch.
- Consumes the FetchInfo bundle (enable, pc, inst), reads operands from an internal register file and fully decodes the instruction.
- Detects load-use hazards and raises a stall request toward the pipeline controller.
- Registers the result into the ID/EX pipeline register (DecodeInfo), which feeds execute.

Parameters:
- RESET_PC, 32'h80000000, pc value loaded into the ID/EX register on reset/flush.
- NREGS, 32, architectural register count; fixed for RV32I, parameterised for the bench only.

Ports:
- clk  in  1  clock; everything on posedge.
- rst  in  1  synchronous, active-high reset.
- info  in  FetchInfo  {enable, pc[31:0], inst[31:0]} from the IF/ID register.
- id_ex_pipe  in  PipeControl  {stall, flush} for the ID/EX register.
- req  out  PipeRequest  stall_req to the pipeline controller.
- ex_is_load  in  1  instruction currently in EX is a valid load.
- ex_rd  in  5  destination register of that EX instruction.
- wb_we  in  1  writeback enable.
- wb_rd  in  5  writeback register index.
- wb_data  in  32  writeback data.
- out  out  DecodeInfo  registered ID/EX contents.
- error  out  1  ID/EX entry holds an illegal instruction.

Behaviour:
Reset:
- out.valid=0, all out fields 0 except out.pc=RESET_PC; error=0.
- req.stall_req=0 while rst is high.
- All register-file entries cleared to 0.

Decode (combinational from info.inst):
- Field extraction: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
- Immediate formats: I, S, B (bit0=0), U (low 12 bits zero), J (bit0=0). All sign-extended from inst[31] to 32 bits.
- Control fields: alu_op, src_b_imm, mem_read, mem_write, mem_size, branch, jal, jalr, reg_write, is_system.
- uses_rs1 / uses_rs2 are set per format. U- and J-types use neither. I-types use rs1 only.
- Legal opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM.
- MISC-MEM (FENCE) decodes as a NOP: reg_write=0.
- ECALL/EBREAK set is_system.
- Illegal when any of:
  - opcode is outside the legal set;
  - OP funct7 is not 0x00, or not 0x20 with funct3 ∈ {0,5};
  - shift-imm funct7 is invalid;
  - BRANCH funct3 ∈ {2,3};
  - LOAD funct3 ∈ {3,6,7};
  - STORE funct3 > 2;
  - JALR funct3 != 0.
- reg_write is forced to 0 when rd==0.

Register file:
- NREGS x 32 entries.
- Write on posedge when wb_we && wb_rd!=0.
- Reads are combinational. A same-cycle write to the register being read is bypassed, so wb_data is returned.
- x0 always reads 0.

Hazard:
- stall_req = info.enable && ex_is_load && ex_rd!=0 && ((uses_rs1 && rs1==ex_rd) || (uses_rs2 && rs2==ex_rd)).
- stall_req is purely combinational.
- The controller responds by stalling PC and IF/ID. This block inserts the bubble itself (see the ID/EX register priority below).

ID/EX register (posedge), priority high to low:
1. rst → reset values.
2. id_ex_pipe.flush → valid=0, pc=RESET_PC, control fields 0.
3. id_ex_pipe.stall → hold all contents, including error.
4. stall_req → bubble: valid=0, control fields 0.
5. Otherwise → load the decode result, with valid=info.enable.

Outputs and timing:
- error = out.valid && out.illegal, taken from the register; no combinational path.
- Latency: the instruction presented in cycle N appears on out in cycle N+1.
- When info.enable=0, a bubble is loaded. Illegal detection and stall_req are suppressed for that slot.
- Flush and stall asserted together: flush wins.
- A hazard while id_ex_pipe.stall=1: stall_req is still driven, and the held contents are kept.

Decomposition:
- Shared package (common.sv): DecodeInfo struct, AluOp enum, MemSize enum, RV32I opcode localparams, RESET_PC constant.
- FetchInfo, PipeControl and PipeRequest are reused from that package unchanged.
- One sub-module: regfile (2 read ports, 1 write port, x0 hardwired to 0, write-to-read bypass).
- Decode logic is a function or always_comb block inside decode_stage.

Test Plan:
- Reset then info={1, 0x80000000, 0x00500093} (addi x1,x0,5) → next cycle out.valid=1, rd=1, imm=5, reg_write=1, src_b_imm=1, error=0.
- wb_we=1, wb_rd=3, wb_data=0xDEADBEEF in the same cycle as decoding add x4,x3,x0 → out.rs1_val=0xDEADBEEF (bypass). A write to x0 → x0 still reads 0.
- ex_is_load=1, ex_rd=2, inst=add x5,x2,x1 → stall_req=1 combinationally, next out.valid=0. With ex_is_load=0 → stall_req=0 and the instruction loads normally. With ex_rd=0 → no stall.
- inst=0xFFFFFFFF, enable=1 → next cycle out.valid=1, error=1. Then id_ex_pipe.stall=1 for 3 cycles → error held. Then flush → error=0, out.pc=0x80000000.
- beq with imm=-4 (inst 0xFE000EE3) → imm=0xFFFFFFFC. jal x1,+2048 → imm=0x00000800, jal=1.
- flush=1 and stall=1 simultaneously with a valid instruction → out.valid=0. rst asserted mid-stream → all outputs at reset values next cycle, regfile cleared.
